// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the three-way memory port arbiter.
// Requester indices double as bit positions in req/gnt/rvalid vectors.
package mem_arb_pkg;

    localparam int REQ_DATA         = 0;
    localparam int REQ_FETCH        = 1;
    localparam int REQ_LOADER       = 2;
    localparam int NUM_REQ          = 3;
    localparam int DEF_STARVE_LIMIT = 8;

    typedef enum logic {
        NORMAL = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_select_3.sv
// Fixed-priority one-hot selector: data > fetch > loader, loader first when promoted.
// Purely combinational, no state.
module prio_select_3
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               promote_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (promote_i && req_i[REQ_LOADER]) begin
            gnt_o[REQ_LOADER] = 1'b1;
        end else if (req_i[REQ_DATA]) begin
            gnt_o[REQ_DATA] = 1'b1;
        end else if (req_i[REQ_FETCH]) begin
            gnt_o[REQ_FETCH] = 1'b1;
        end else if (req_i[REQ_LOADER]) begin
            gnt_o[REQ_LOADER] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between data, fetch and loader requesters.
// Grant is same-cycle combinational; read data returns to the owner one cycle later.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [11:0]           wmask,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    input  logic                  l_lock,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  cpu_hold,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_wmask,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e          state_q;
    logic [CNT_W-1:0]    starve_cnt_q;
    logic [CNT_W-1:0]    starve_cnt_d;
    logic [1:0]          owner_q;
    logic                pend_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                locked_eff;
    logic                starved;
    logic [2:0]          req_eff;
    logic [2:0]          sel;
    logic [2:0]          rd_gnt;

    // A locked loader that drops its request releases the port in that same cycle.
    assign locked_eff = (state_q == LOCKED) && req[REQ_LOADER];
    assign starved    = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    assign req_eff    = locked_eff ? (req & 3'b100) : req;

    prio_select_3 u_prio (
        .req_i     (req_eff),
        .promote_i (locked_eff | starved),
        .gnt_o     (sel)
    );

    assign gnt      = rst_n ? sel : 3'b000;
    assign cpu_hold = locked_eff | gnt[REQ_LOADER];
    assign rd_gnt   = gnt & ~we;

    always_comb begin
        mem_en    = |gnt;
        mem_we    = 1'b0;
        mem_wmask = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mem_we    = we[i];
                mem_wmask = wmask[4*i +: 4];
                mem_addr  = addr[ADDR_W*i +: ADDR_W];
                mem_wdata = wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        if (!req[REQ_LOADER] || gnt[REQ_LOADER]) begin
            starve_cnt_d = '0;
        end else if (starved) begin
            starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= NORMAL;
            starve_cnt_q <= '0;
            owner_q      <= 2'd0;
            pend_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                NORMAL:  if (gnt[REQ_LOADER] && l_lock) state_q <= LOCKED;
                LOCKED:  if (!req[REQ_LOADER] || !l_lock) state_q <= NORMAL;
                default: state_q <= NORMAL;
            endcase
            pend_q <= |rd_gnt;
            if (|rd_gnt) owner_q <= onehot_to_idx(rd_gnt);
            if (pend_q) rdata_q <= mem_rdata;
        end
    end

    // rdata_q keeps the last returned word so rdata holds between reads.
    assign rvalid = pend_q ? (3'b001 << owner_q) : 3'b000;
    assign rdata  = pend_q ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scenario tasks plus randomized traffic against a reference model.
module tb_mem_port_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    req, we;
    logic [11:0]   wmask;
    logic [35:0]   addr;
    logic [95:0]   wdata;
    logic          l_lock;
    logic [2:0]    gnt, rvalid;
    logic [31:0]   rdata;
    logic          cpu_hold, mem_en, mem_we;
    logic [3:0]    mem_wmask;
    logic [11:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wmask(wmask), .addr(addr),
        .wdata(wdata), .l_lock(l_lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .cpu_hold(cpu_hold), .mem_en(mem_en), .mem_we(mem_we), .mem_wmask(mem_wmask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] mem [4096];

    // Reference model state
    bit          m_locked;
    int          m_starve;
    bit          m_pend;
    int          m_owner;
    logic [31:0] m_pdata, m_last;

    logic [2:0]  e_gnt, e_rvalid;
    logic        e_hold;
    logic [31:0] e_rdata;
    logic [49:0] e_bus;

    function automatic int gidx(input logic [2:0] g);
        for (int i = 0; i < 3; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_starve = 0; m_pend = 0; m_owner = 0; m_last = '0; m_pdata = '0;
    endtask

    task automatic predict();
        int  w;
        bit  lk;
        lk    = m_locked && (req[2] === 1'b1);
        e_gnt = 3'b000;
        if (rst_n === 1'b1) begin
            if (req[2] && (lk || m_starve >= LIMIT)) e_gnt = 3'b100;
            else if (req[0]) e_gnt = 3'b001;
            else if (req[1]) e_gnt = 3'b010;
            else if (req[2]) e_gnt = 3'b100;
        end
        e_hold = lk || e_gnt[2];
        w = gidx(e_gnt);
        e_bus = '0;
        if (w >= 0) e_bus = {1'b1, we[w], wmask[4*w +: 4], addr[12*w +: 12], wdata[32*w +: 32]};
        e_rvalid = m_pend ? 3'(1 << m_owner) : 3'b000;
        e_rdata  = m_pend ? m_pdata : m_last;
    endtask

    // Advance one clock: update the model and the memory it emulates.
    task automatic tick();
        int          w;
        logic [11:0] a;
        logic [31:0] word;
        predict();
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            model_reset();
        end else begin
            w      = gidx(e_gnt);
            m_last = e_rdata;
            m_pend = 0;
            if (w >= 0) begin
                a = addr[12*w +: 12];
                if (we[w]) begin
                    word = mem[a];
                    for (int b = 0; b < 4; b++)
                        if (wmask[4*w + b]) word[8*b +: 8] = wdata[32*w + 8*b +: 8];
                    mem[a] = word;
                end else begin
                    m_pend = 1; m_owner = w; m_pdata = mem[a];
                end
            end
            if (!req[2] || w == 2) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            m_locked = (w == 2) && l_lock;
        end
        #1;
        mem_rdata = m_pend ? m_pdata : $urandom;
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [11:0] m,
                         input logic [35:0] a, input logic [95:0] d, input logic lk);
        req = r; we = w; wmask = m; addr = a; wdata = d; l_lock = lk;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(3'b000, 3'b000, '0, '0, '0, 1'b0);
        mem_rdata = '0;
        model_reset();
        #2;
        checks++;
        if ({gnt, rvalid, rdata, cpu_hold, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b rvalid=%b rdata=%h hold=%b en=%b exp all zero",
                     gnt, rvalid, rdata, cpu_hold, mem_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({gnt, rvalid, rdata, cpu_hold, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL post_release_idle got gnt=%b rvalid=%b rdata=%h exp all zero", gnt, rvalid, rdata);
        end
        tick();
        mem[12'h010] = 32'hDEADBEEF;
        drive(3'b001, 3'b000, '0, {24'h0, 12'h010}, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001 || mem_addr !== 12'h010 || mem_en !== 1'b1) begin
            errors++;
            $display("FAIL first_read_grant got gnt=%b addr=%h en=%b exp 001/010/1", gnt, mem_addr, mem_en);
        end
        tick();
        drive(3'b000, 3'b000, '0, '0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (rvalid !== 3'b001 || rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL first_read_return got rvalid=%b rdata=%h exp 001/deadbeef", rvalid, rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        drive(3'b111, 3'b000, '0, {12'h300, 12'h200, 12'h100}, '0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            predict();
            checks++;
            if (gnt !== (i < 8 ? 3'b001 : 3'b100)) begin
                errors++;
                $display("FAIL starve_gnt cyc=%0d got=%b exp=%b", i, gnt, (i < 8 ? 3'b001 : 3'b100));
            end
            checks++;
            if (cpu_hold !== (i == 8)) begin
                errors++;
                $display("FAIL starve_hold cyc=%0d got=%b exp=%b", i, cpu_hold, (i == 8));
            end
            checks++;
            if (rvalid !== e_rvalid || rdata !== e_rdata) begin
                errors++;
                $display("FAIL starve_rdata cyc=%0d got=%b/%h exp=%b/%h", i, rvalid, rdata, e_rvalid, e_rdata);
            end
            tick();
        end
        drive(3'b000, 3'b000, '0, '0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (rvalid !== 3'b100 || rdata !== mem[12'h300]) begin
            errors++;
            $display("FAIL starve_loader_return got=%b/%h exp=100/%h", rvalid, rdata, mem[12'h300]);
        end
        tick();
    endtask

    task automatic test_lock();
        drive(3'b100, 3'b100, 12'hF00, {12'h020, 24'h0}, {32'hCAFEF00D, 64'h0}, 1'b1);
        @(negedge clk);
        checks++;
        if (gnt !== 3'b100 || mem_we !== 1'b1 || cpu_hold !== 1'b1 || mem_addr !== 12'h020 || mem_wmask !== 4'hF) begin
            errors++;
            $display("FAIL lock_enter got gnt=%b we=%b hold=%b addr=%h exp 100/1/1/020", gnt, mem_we, cpu_hold, mem_addr);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(3'b101, 3'b100, 12'hF00, {12'(12'h021 + i), 12'h0, 12'h040}, {32'($urandom), 64'h0}, (i < 3));
            @(negedge clk);
            predict();
            checks++;
            if (gnt !== 3'b100 || cpu_hold !== 1'b1 || gnt !== e_gnt) begin
                errors++;
                $display("FAIL lock_hold cyc=%0d got gnt=%b hold=%b exp 100/1", i, gnt, cpu_hold);
            end
            tick();
        end
        drive(3'b101, 3'b000, '0, {12'h0, 12'h0, 12'h020}, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL lock_exit_data got gnt=%b hold=%b exp 001/0", gnt, cpu_hold);
        end
        tick();
        drive(3'b000, 3'b000, '0, '0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (rvalid !== 3'b001 || rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL lock_readback got=%b/%h exp=001/cafef00d", rvalid, rdata);
        end
        tick();
        drive(3'b100, 3'b100, 12'h300, {12'h050, 24'h0}, {32'h1234_5678, 64'h0}, 1'b1);
        tick();
        drive(3'b011, 3'b000, '0, {12'h0, 12'h060, 12'h070}, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL lock_drop_req got gnt=%b hold=%b exp 001/0", gnt, cpu_hold);
        end
        tick();
        drive(3'b000, 3'b000, '0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) drive(3'b010, 3'b000, '0, {12'h0, 12'h000, 12'h0}, '0, 1'b0);
            else            drive(3'b001, 3'b000, '0, {12'h0, 12'h0, 12'h100}, '0, 1'b0);
            @(negedge clk);
            checks++;
            if (mem_en !== 1'b1) begin
                errors++;
                $display("FAIL b2b_en cyc=%0d got=%b exp=1", i, mem_en);
            end
            if (i > 0) begin
                checks++;
                if (rvalid !== (i % 2 == 1 ? 3'b010 : 3'b001) ||
                    rdata !== (i % 2 == 1 ? mem[12'h000] : mem[12'h100])) begin
                    errors++;
                    $display("FAIL b2b_return cyc=%0d got=%b/%h", i, rvalid, rdata);
                end
            end
            tick();
        end
        drive(3'b000, 3'b000, '0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive(3'b110, 3'b000, '0, {12'h077, 12'h055, 12'h0}, '0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rvalid !== 3'b000 || gnt !== 3'b000 || rdata !== '0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got rvalid=%b gnt=%b rdata=%h exp 000/000/0", rvalid, gnt, rdata);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b000, 3'b000, '0, '0, '0, 1'b0);
        #1;
        checks++;
        if (rvalid !== 3'b000) begin
            errors++;
            $display("FAIL midreset_stale got rvalid=%b exp=000", rvalid);
        end
        tick();
        drive(3'b111, 3'b000, '0, {12'h003, 12'h002, 12'h001}, '0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (gnt !== (i < 8 ? 3'b001 : 3'b100)) begin
                errors++;
                $display("FAIL midreset_starve cyc=%0d got=%b exp=%b", i, gnt, (i < 8 ? 3'b001 : 3'b100));
            end
            tick();
        end
        drive(3'b000, 3'b000, '0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 12'($urandom),
                  {12'($urandom), 12'($urandom), 12'($urandom)},
                  {32'($urandom), 32'($urandom), 32'($urandom)}, ($urandom_range(0, 3) != 0));
            @(negedge clk);
            predict();
            checks++;
            if (gnt !== e_gnt) begin
                errors++;
                $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", i, gnt, e_gnt);
            end
            checks++;
            if (cpu_hold !== e_hold) begin
                errors++;
                $display("FAIL rand_hold cyc=%0d got=%b exp=%b", i, cpu_hold, e_hold);
            end
            checks++;
            if ({mem_en, mem_we, mem_wmask, mem_addr, mem_wdata} !== e_bus) begin
                errors++;
                $display("FAIL rand_bus cyc=%0d got=%h exp=%h", i,
                         {mem_en, mem_we, mem_wmask, mem_addr, mem_wdata}, e_bus);
            end
            checks++;
            if (rvalid !== e_rvalid || rdata !== e_rdata) begin
                errors++;
                $display("FAIL rand_rdata cyc=%0d got=%b/%h exp=%b/%h", i, rvalid, rdata, e_rvalid, e_rdata);
            end
            tick();
        end
        drive(3'b000, 3'b000, '0, '0, '0, 1'b0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        test_reset();
        test_starvation();
        test_lock();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
